// File: rtl/param_sync_fifo_pkg.sv
// param_sync_fifo_pkg: shared operation encoding and pointer-wrap helper for param_sync_fifo.
package param_sync_fifo_pkg;

    typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD, OP_RDWR} fifo_op_e;

    // Wraps at depth-1 explicitly so any depth works, not only powers of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// param_sync_fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read.
module param_sync_fifo_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO, any depth >= 2, show-ahead read, level and threshold flags.
// Define PARAM_SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter  int DEPTH     = 16,
    parameter  int WIDTH     = 8,
    parameter  int AF_THRESH = DEPTH - 2,
    parameter  int AE_THRESH = 2,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata;
    logic             wr_ok, rd_ok;
    fifo_op_e         op;

    // Flags decode from the registered count only, never from this cycle's requests.
    assign full         = count_q == LW'(DEPTH);
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= LW'(AF_THRESH);
    assign almost_empty = count_q <= LW'(AE_THRESH);
    assign level        = count_q;
    assign dout         = empty ? '0 : rdata;

    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    assign op    = fifo_op_e'({rd_ok, wr_ok});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op)
            OP_WR: begin
                wr_ptr_d = AW'(next_ptr(32'(wr_ptr_q), DEPTH));
                count_d  = count_q + LW'(1);
            end
            OP_RD: begin
                rd_ptr_d = AW'(next_ptr(32'(rd_ptr_q), DEPTH));
                count_d  = count_q - LW'(1);
            end
            OP_RDWR: begin
                wr_ptr_d = AW'(next_ptr(32'(wr_ptr_q), DEPTH));
                rd_ptr_d = AW'(next_ptr(32'(rd_ptr_q), DEPTH));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    param_sync_fifo_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_ram (
        .clk   (clk),
        .we    (wr_ok & ~clr),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= clr ? 1'b0 : ovf_q | (wr_en & full);
            unf_q <= clr ? 1'b0 : unf_q | (rd_en & empty);
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: queue-based reference model with a negedge monitor; directed phases then random traffic.
module tb_param_sync_fifo;

    localparam int DEPTH = 5;
    localparam int WIDTH = 8;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             full, empty, almost_full, almost_empty;
    logic [LW-1:0]    level;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    logic             overflow, underflow;
    bit               ovf_m, unf_m;
`endif

    logic [WIDTH-1:0] exp_q [$];
    int               n_chk = 0;
    int               n_fail = 0;

    param_sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level)
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the FIFO is just a queue; acceptance follows from its size.
    always @(posedge clk) begin
        if (rst) begin
            if (clr) begin
                exp_q.delete();
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
                ovf_m = 0;
                unf_m = 0;
`endif
            end else begin
                automatic int sz = exp_q.size();
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
                if (wr_en && sz == DEPTH) ovf_m = 1;
                if (rd_en && sz == 0) unf_m = 1;
`endif
                if (rd_en && sz > 0) void'(exp_q.pop_front());
                if (wr_en && sz < DEPTH) exp_q.push_back(din);
            end
        end
    end

    // Monitor: compare every visible output against the model mid-cycle.
    always @(negedge clk) begin
        automatic int sz = exp_q.size();
        chk("level", int'(level), sz);
        chk("empty", int'(empty), int'(sz == 0));
        chk("full", int'(full), int'(sz == DEPTH));
        chk("almost_full", int'(almost_full), int'(sz >= AF));
        chk("almost_empty", int'(almost_empty), int'(sz <= AE));
        chk("dout", int'(dout), sz == 0 ? 0 : int'(exp_q[0]));
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow", int'(overflow), int'(ovf_m));
        chk("underflow", int'(underflow), int'(unf_m));
`endif
    end

    task automatic step(input bit w, input bit r, input bit c, input logic [WIDTH-1:0] d);
        wr_en = w;
        rd_en = r;
        clr   = c;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        step(1, 0, 0, 8'hA1);
        step(1, 0, 0, 8'hA2);
        wr_en = 0;
        rd_en = 0;
        rst   = 1'b0;
        exp_q.delete();
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
        ovf_m = 0;
        unf_m = 0;
`endif
        #1;
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_full", int'(full), 0);
        chk("async_rst_dout", int'(dout), 0);
        @(negedge clk) rst = 1'b1;
        #1;
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        foreach (dut.level[i]) ;
        for (int i = 1; i <= DEPTH + 1; i++) step(1, 0, 0, WIDTH'(i * 8'h11));
        step(1, 1, 0, 8'hEE);
        step(1, 1, 0, 8'hDD);
        for (int i = 0; i <= DEPTH; i++) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h5A);
        step(1, 1, 0, 8'h6B);
        step(1, 0, 0, 8'h7C);
        step(1, 1, 0, 8'h8D);
        for (int i = 0; i <= DEPTH; i++) step(1, 0, 0, 8'h90 + WIDTH'(i));
        step(1, 0, 1, 8'hAA);
        step(1, 0, 0, 8'h01);
        step(1, 0, 0, 8'h02);
        for (int i = 0; i < 12; i++) step(1, 1, 0, WIDTH'(8'h30 + i));
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 2, WIDTH'($urandom_range(0, 255)));
        step(0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
